// File: rtl/accumulator_datapath_pkg.sv
// Shared encodings for the accumulator CPU datapath and its control unit.
// Opcodes, internal bus selects and ALU operation select.
package accumulator_datapath_pkg;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_STORE  = 3'd1;
  localparam logic [2:0] OP_ADD    = 3'd2;
  localparam logic [2:0] OP_SUB    = 3'd3;
  localparam logic [2:0] OP_JUMP   = 3'd4;
  localparam logic [2:0] OP_JUMPEQ = 3'd5;

  typedef enum logic [1:0] {
    BUS_MEM = 2'd0,
    BUS_DR  = 2'd1,
    BUS_PC  = 2'd2,
    BUS_AC  = 2'd3
  } bus_sel_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/datapath_alu.sv
// Combinational add/sub unit; carry is the add carry-out or the subtract borrow.
module datapath_alu
  import accumulator_datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] ext;

  // One extra bit: for subtraction it goes high exactly when a < b unsigned.
  always_comb begin
    if (alu_op_e'(op) == ALU_SUB) ext = {1'b0, a} - {1'b0, b};
    else                          ext = {1'b0, a} + {1'b0, b};
  end

  assign result = ext[DATA_W-1:0];
  assign carry  = ext[DATA_W];
  assign zero   = (ext[DATA_W-1:0] == '0);

endmodule

// File: rtl/accumulator_datapath.sv
// Register-transfer datapath (AR, DR, PC, AC, IR, bus mux, ALU) of the accumulator CPU.
// Define DATAPATH_CARRY_EN to add the C (carry/borrow) flag output.
module accumulator_datapath
  import accumulator_datapath_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int PC_RESET = 0,
  localparam int ADDR_W   = DATA_W - 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ARLoad,
  input  logic              DRLoad,
  input  logic              PCLoad,
  input  logic              ACLoad,
  input  logic              IRLoad,
  input  logic              ALUSel,
  input  logic              PCInc,
  input  logic              memRW,
  input  logic [1:0]        BusSel,
  output logic [2:0]        IR,
  output logic              Z,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              MemWE
`ifdef DATAPATH_CARRY_EN
  ,
  output logic              C
`endif
);

  logic [ADDR_W-1:0] ar_q, ar_d, pc_q, pc_d;
  logic [DATA_W-1:0] dr_q, dr_d, ac_q, ac_d;
  logic [2:0]        ir_q, ir_d;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_zero;

  always_comb begin
    unique case (bus_sel_e'(BusSel))
      BUS_MEM: bus = MemRdata;
      BUS_DR:  bus = dr_q;
      BUS_PC:  bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      BUS_AC:  bus = ac_q;
    endcase
  end

  datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (ac_q),
    .b      (dr_q),
    .op     (ALUSel),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // NOTE: every _d starts as its _q so an un-strobed path holds state and no latch is inferred.
  always_comb begin
    ar_d = ar_q;
    dr_d = dr_q;
    pc_d = pc_q;
    ac_d = ac_q;
    ir_d = ir_q;
    if (ARLoad) ar_d = bus[ADDR_W-1:0];
    if (DRLoad) dr_d = bus;
    if (IRLoad) ir_d = bus[DATA_W-1:DATA_W-3];
    if (PCLoad)     pc_d = bus[ADDR_W-1:0];
    else if (PCInc) pc_d = pc_q + ADDR_W'(1);
    // LOAD and ADD share strobes; only the latched opcode tells them apart.
    if (ACLoad) ac_d = (ir_q == OP_LOAD) ? bus : alu_result;
  end

  // NOTE: state flops use non-blocking assignment so every load samples the pre-edge bus.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ar_q <= '0;
      dr_q <= '0;
      pc_q <= ADDR_W'(PC_RESET);
      ac_q <= '0;
      ir_q <= '0;
    end else begin
      ar_q <= ar_d;
      dr_q <= dr_d;
      pc_q <= pc_d;
      ac_q <= ac_d;
      ir_q <= ir_d;
    end
  end

`ifdef DATAPATH_CARRY_EN
  logic c_q, c_d;

  always_comb begin
    c_d = c_q;
    if (ACLoad && (ir_q != OP_LOAD)) c_d = alu_carry;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) c_q <= 1'b0;
    else     c_q <= c_d;
  end

  assign C = c_q;
  logic unused_alu;
  assign unused_alu = alu_zero;
`else
  logic unused_alu;
  assign unused_alu = alu_carry ^ alu_zero;
`endif

  assign IR       = ir_q;
  assign Z        = (ac_q == '0);
  assign MemAddr  = ar_q;
  assign MemWdata = bus;
  assign MemWE    = memRW;

endmodule

// File: tb/tb_accumulator_datapath.sv
// Scoreboard bench for accumulator_datapath: stimulus pushes expectations, a monitor pops and compares.
module tb_accumulator_datapath;
  import accumulator_datapath_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = DATA_W - 3;

  localparam int M_AR  = 1;
  localparam int M_DR  = 2;
  localparam int M_PC  = 4;
  localparam int M_AC  = 8;
  localparam int M_IR  = 16;
  localparam int M_SUB = 32;
  localparam int M_INC = 64;
  localparam int M_WR  = 128;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              ARLoad, DRLoad, PCLoad, ACLoad, IRLoad, ALUSel, PCInc, memRW;
  logic [1:0]        BusSel;
  logic [2:0]        IR;
  logic              Z;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;
  logic              MemWE;
`ifdef DATAPATH_CARRY_EN
  logic              C;
`endif

  accumulator_datapath #(.DATA_W(DATA_W), .PC_RESET(0)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ARLoad   (ARLoad),
    .DRLoad   (DRLoad),
    .PCLoad   (PCLoad),
    .ACLoad   (ACLoad),
    .IRLoad   (IRLoad),
    .ALUSel   (ALUSel),
    .PCInc    (PCInc),
    .memRW    (memRW),
    .BusSel   (BusSel),
    .IR       (IR),
    .Z        (Z),
    .MemAddr  (MemAddr),
    .MemWdata (MemWdata),
    .MemRdata (MemRdata),
    .MemWE    (MemWE)
`ifdef DATAPATH_CARRY_EN
    ,
    .C        (C)
`endif
  );

  always #20 CLK = ~CLK;

  logic [DATA_W-1:0] mem [32];
  assign MemRdata = mem[MemAddr];
  always @(posedge CLK) if (MemWE) mem[MemAddr] <= MemWdata;

  typedef enum int {OBS_WDATA, OBS_ADDR, OBS_IR, OBS_Z, OBS_WE, OBS_C, OBS_RDATA} obs_e;
  typedef struct {
    string             name;
    obs_e              sel;
    logic [DATA_W-1:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event obs_ev;
  int   n_pass  = 0;
  int   n_total = 0;
  int   ar_model = 0;

  function automatic logic [DATA_W-1:0] actual(input obs_e s);
    logic [DATA_W-1:0] v;
    v = '0;
    case (s)
      OBS_WDATA: v = MemWdata;
      OBS_ADDR:  v = {{(DATA_W-ADDR_W){1'b0}}, MemAddr};
      OBS_IR:    v = {5'd0, IR};
      OBS_Z:     v = {7'd0, Z};
      OBS_WE:    v = {7'd0, MemWE};
`ifdef DATAPATH_CARRY_EN
      OBS_C:     v = {7'd0, C};
`endif
      OBS_RDATA: v = MemRdata;
      default:   v = 'x;
    endcase
    return v;
  endfunction

  // Monitor: consumes expectations whenever the stimulus side announces a sample point.
  initial begin
    forever begin
      @(obs_ev);
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [DATA_W-1:0] a;
        e = sb_q.pop_front();
        a = actual(e.sel);
        n_total++;
        if (a === e.exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, a, e.exp);
      end
    end
  end

  task automatic drive(input int m, input logic [1:0] bus);
    ARLoad = (m & M_AR)  != 0;
    DRLoad = (m & M_DR)  != 0;
    PCLoad = (m & M_PC)  != 0;
    ACLoad = (m & M_AC)  != 0;
    IRLoad = (m & M_IR)  != 0;
    ALUSel = (m & M_SUB) != 0;
    PCInc  = (m & M_INC) != 0;
    memRW  = (m & M_WR)  != 0;
    BusSel = bus;
  endtask

  task automatic tick(input int m, input logic [1:0] bus);
    drive(m, bus);
    @(posedge CLK);
    @(negedge CLK);
    drive(0, BUS_MEM);
  endtask

  task automatic observe(input string name, input obs_e sel, input logic [1:0] bus,
                         input logic [DATA_W-1:0] exp);
    exp_t e;
    BusSel = bus;
    #1;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
    -> obs_ev;
    #1;
  endtask

  task automatic set_dr(input logic [DATA_W-1:0] v);
    mem[ar_model] = v;
    tick(M_DR, BUS_MEM);
  endtask

  task automatic set_ir(input logic [2:0] op);
    set_dr({op, 5'd0});
    tick(M_IR, BUS_DR);
  endtask

  task automatic set_ac_load(input logic [DATA_W-1:0] v);
    set_ir(OP_LOAD);
    set_dr(v);
    tick(M_AC, BUS_DR);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 8'h05;
    mem[5] = 8'h2A;
    drive(0, BUS_MEM);

    // Reset state
    #2;
    observe("rst_addr", OBS_ADDR,  BUS_MEM, 8'h00);
    observe("rst_ir",   OBS_IR,    BUS_MEM, 8'h00);
    observe("rst_z",    OBS_Z,     BUS_MEM, 8'h01);
    observe("rst_we",   OBS_WE,    BUS_MEM, 8'h00);
    observe("rst_pc",   OBS_WDATA, BUS_PC,  8'h00);
    observe("rst_dr",   OBS_WDATA, BUS_DR,  8'h00);
    observe("rst_ac",   OBS_WDATA, BUS_AC,  8'h00);
    @(negedge CLK);
    RST = 1'b0;

    // Fetch and LOAD 5
    tick(M_AR, BUS_PC);
    tick(M_DR | M_INC, BUS_MEM);
    tick(M_AR | M_IR, BUS_DR);
    ar_model = 5;
    observe("fetch_ar", OBS_ADDR,  BUS_MEM, 8'h05);
    observe("fetch_ir", OBS_IR,    BUS_MEM, 8'h00);
    observe("fetch_pc", OBS_WDATA, BUS_PC,  8'h01);
    tick(M_DR, BUS_MEM);
    tick(M_AC, BUS_DR);
    observe("load_ac", OBS_WDATA, BUS_AC, 8'h2A);
    observe("load_z",  OBS_Z,     BUS_AC, 8'h00);

    // SUB to zero; Z must not move before the edge
    set_ir(OP_SUB);
    set_dr(8'h2A);
    observe("sub_ir", OBS_IR, BUS_MEM, 8'h03);
    drive(M_AC | M_SUB, BUS_DR);
    observe("sub_z_pre_edge", OBS_Z, BUS_DR, 8'h00);
    @(posedge CLK);
    @(negedge CLK);
    drive(0, BUS_MEM);
    observe("sub_ac", OBS_WDATA, BUS_AC, 8'h00);
    observe("sub_z",  OBS_Z,     BUS_AC, 8'h01);
`ifdef DATAPATH_CARRY_EN
    observe("sub_c",  OBS_C,     BUS_AC, 8'h00);
`endif

    // ADD with carry-out
    set_ac_load(8'hF0);
    observe("ld_f0_ac", OBS_WDATA, BUS_AC, 8'hF0);
    set_ir(OP_ADD);
    set_dr(8'h20);
    tick(M_AC, BUS_DR);
    observe("add_ac", OBS_WDATA, BUS_AC, 8'h10);
    observe("add_z",  OBS_Z,     BUS_AC, 8'h00);
`ifdef DATAPATH_CARRY_EN
    observe("add_c",  OBS_C,     BUS_AC, 8'h01);
`endif

    // STORE to address 7
    set_dr(8'h07);
    tick(M_AR, BUS_DR);
    ar_model = 7;
    tick(M_DR, BUS_AC);
    observe("store1_dr", OBS_WDATA, BUS_DR, 8'h10);
    drive(M_WR, BUS_DR);
    observe("store2_we",    OBS_WE,    BUS_DR, 8'h01);
    observe("store2_wdata", OBS_WDATA, BUS_DR, 8'h10);
    observe("store2_addr",  OBS_ADDR,  BUS_DR, 8'h07);
    @(posedge CLK);
    @(negedge CLK);
    drive(0, BUS_MEM);
    observe("store_mem", OBS_RDATA, BUS_MEM, 8'h10);
    observe("store_we_off", OBS_WE, BUS_MEM, 8'h00);

    // AC self-load under LOAD opcode: holds value, leaves C alone
    set_ir(OP_LOAD);
    tick(M_AC, BUS_AC);
    observe("ac_self_load", OBS_WDATA, BUS_AC, 8'h10);
`ifdef DATAPATH_CARRY_EN
    observe("c_hold_on_load", OBS_C, BUS_AC, 8'h01);
`endif

    // PC load priority and wrap
    set_dr(8'h03);
    tick(M_PC, BUS_DR);
    observe("pc_load", OBS_WDATA, BUS_PC, 8'h03);
    set_dr(8'h9F);
    tick(M_PC | M_INC, BUS_DR);
    observe("pc_load_wins", OBS_WDATA, BUS_PC, 8'h1F);
    tick(M_INC, BUS_MEM);
    observe("pc_wrap", OBS_WDATA, BUS_PC, 8'h00);

    // Asynchronous reset pulse between edges
    tick(M_INC, BUS_MEM);
    set_ir(3'd5);
    observe("pre_rst_ir", OBS_IR,    BUS_MEM, 8'h05);
    observe("pre_rst_pc", OBS_WDATA, BUS_PC,  8'h01);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    RST = 1'b0;
    observe("arst_addr", OBS_ADDR,  BUS_MEM, 8'h00);
    observe("arst_ir",   OBS_IR,    BUS_MEM, 8'h00);
    observe("arst_z",    OBS_Z,     BUS_MEM, 8'h01);
    observe("arst_pc",   OBS_WDATA, BUS_PC,  8'h00);
    observe("arst_dr",   OBS_WDATA, BUS_DR,  8'h00);
    observe("arst_ac",   OBS_WDATA, BUS_AC,  8'h00);
`ifdef DATAPATH_CARRY_EN
    observe("arst_c",    OBS_C,     BUS_AC,  8'h00);
`endif

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) #1;
    if (sb_q.size() > 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0 pending", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/accumulator_datapath.md
Name: accumulator_datapath

Overview:
Register-transfer datapath for the accumulator CPU. It consumes the per-cycle control strobes from the control unit and returns the 3-bit opcode (IR) and zero flag (Z) that the control unit sequences on. It holds the AR, DR, PC, AC and IR registers, the 4-way internal bus mux and the add/sub ALU. It drives an external memory with combinational read and clocked write.

Parameters:
DATA_W, 8, word width of memory, DR, AC and bus; instruction = {opcode[2:0], address[DATA_W-4:0]}
PC_RESET, 0, PC value after reset
(localparam ADDR_W = DATA_W-3, width of AR and PC)

Ports:
CLK  in  1  clock; all registers update on posedge (control unit changes state on negedge)
RST  in  1  asynchronous active-high reset
ARLoad  in  1  AR <= bus[ADDR_W-1:0]
DRLoad  in  1  DR <= bus
PCLoad  in  1  PC <= bus[ADDR_W-1:0]
ACLoad  in  1  AC <= ACin (see Behaviour)
IRLoad  in  1  IR <= bus[DATA_W-1:DATA_W-3]
ALUSel  in  1  0 = AC+DR, 1 = AC-DR
PCInc  in  1  PC <= PC+1
memRW  in  1  1 = write memory this cycle
BusSel  in  2  0 = MemRdata, 1 = DR, 2 = {0,PC}, 3 = AC
IR  out  3  opcode register to control unit
Z  out  1  1 when AC == 0
MemAddr  out  ADDR_W  = AR (combinational)
MemWdata  out  DATA_W  = bus (combinational)
MemRdata  in  DATA_W  asynchronous-read data at MemAddr
MemWE  out  1  = memRW (combinational)

Behaviour:
- Reset (async, immediate): AR=0, DR=0, PC=PC_RESET, AC=0, IR=0. Hence Z=1, MemAddr=0, MemWE follows memRW.
- Bus: pure combinational mux on BusSel. PC is zero-extended to DATA_W.
- ALU: result = AC±DR mod 2^DATA_W, no saturation.
- ACin: if IR==3'd0 (LOAD), ACin = bus; otherwise ACin = ALU result. This disambiguates LOAD2 from ADD2, which drive identical strobes.
- PC: PCLoad has priority over PCInc. PCInc wraps from 2^ADDR_W-1 to 0.
- All loads in the same cycle are independent and sample the pre-edge bus. A register loading from itself (e.g. DRLoad with BusSel=1) holds its value. ARLoad+IRLoad together (fetch 3) split one DR word into address and opcode.
- Z is combinational from the AC register. It updates one posedge after ACLoad.
- Memory write: the memory captures MemWdata at posedge while MemWE=1. The datapath does not gate memRW.
- Opcodes 6 and 7 load into IR like any other value. The datapath takes no special action.
- Single-cycle latency for every register transfer; no stalls, no handshake.
- RST mid-instruction clears registers regardless of strobes. The control unit has no reset, so the system bench must align it.

Optional Feature:
Macro DATAPATH_CARRY_EN.
- Defined: adds output port C (1 bit), reset 0. C is updated only on an ACLoad whose ACin comes from the ALU:
  - add: C = carry-out.
  - sub: C = borrow (1 when AC < DR unsigned).
  - ACLoad with IR==0 leaves C unchanged.
- Undefined: no C port, no carry logic.

Decomposition:
- Shared package: opcode constants (OP_LOAD=0, OP_STORE=1, OP_ADD=2, OP_SUB=3, OP_JUMP=4, OP_JUMPEQ=5) and BusSel encodings (BUS_MEM=0, BUS_DR=1, BUS_PC=2, BUS_AC=3). The control unit uses the same package.
- One sub-module, datapath_alu: combinational add/sub with result, carry/borrow and zero outputs.

Test Plan:
- Reset, PC_RESET=0, mem[0]=0x05, mem[5]=0x2A; drive fetch1 (ARLoad, Bus=2), fetch2 (DRLoad, Bus=0, PCInc), fetch3 (ARLoad, IRLoad, Bus=1), load1, load2 -> after fetch3 AR=5, IR=0, PC=1; after load2 AC=0x2A, Z=0.
- AC=0x2A, IR=3, DR=0x2A; ACLoad, ALUSel=1, Bus=1 -> AC=0x00, Z=1, C=0 with macro.
- AC=0xF0, IR=2, DR=0x20; ACLoad, ALUSel=0 -> AC=0x10, Z=0, C=1 with macro.
- AC=0x10, AR=7; Store1 (DRLoad, Bus=3), then Store2 (memRW, Bus=1) -> DR=0x10; during Store2 MemWE=1, MemWdata=0x10, MemAddr=7.
- DR=0x9F, PC=3; PCLoad+PCInc, Bus=1 -> PC=0x1F (load wins). Next PCInc -> PC=0x00 (wrap).
- Registers non-zero; pulse RST between clock edges -> all registers clear immediately, PC=PC_RESET, Z=1, with no clock edge required.
